// File: rtl/quant_pkg.sv
// Shared constants, FSM state type and reset-threshold helper for the input quantizer.
package quant_pkg;

    localparam int Q_W = 2;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Default thresholds split the input range into four equal bands.
    function automatic int unsigned thr_init(input int unsigned j, input int unsigned in_w);
        return (j + 1) << (in_w - 2);
    endfunction

endpackage

// File: rtl/quant_cmp3.sv
// Combinational 3-threshold quantizer: counts how many thresholds the sample meets or exceeds.
module quant_cmp3
    import quant_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] x,
    input  logic [IN_W-1:0] t0,
    input  logic [IN_W-1:0] t1,
    input  logic [IN_W-1:0] t2,
    output logic [Q_W-1:0]  code
);

    assign code = {1'b0, (x >= t0)} + {1'b0, (x >= t1)} + {1'b0, (x >= t2)};

endmodule

// File: rtl/input_quantizer_frame.sv
// Streams raw samples in, quantizes each to a 2-bit code and emits a packed frame once complete.
module input_quantizer_frame
    import quant_pkg::*;
#(
    parameter  int NUM_FEAT = 16,
    parameter  int IN_W     = 8,
    localparam int FI_W     = $clog2(NUM_FEAT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [Q_W*NUM_FEAT-1:0] m_data,
    output logic                    frame_err,
    input  logic                    cfg_we,
    input  logic [FI_W-1:0]         cfg_feat,
    input  logic [1:0]              cfg_sel,
    input  logic [IN_W-1:0]         cfg_data
);

    localparam logic [FI_W-1:0] LAST_IDX = FI_W'(NUM_FEAT - 1);

    logic [IN_W-1:0]         thr [NUM_FEAT][3];
    state_t                  state_q, state_d;
    logic [FI_W-1:0]         idx_q, idx_d;
    logic                    err_d;
    logic                    load;
    logic [Q_W-1:0]          code;
    logic [Q_W*NUM_FEAT-1:0] pack_q;
    logic                    cfg_ok;

    assign cfg_ok = cfg_we && (cfg_sel != 2'd3) && (int'(cfg_feat) < NUM_FEAT);

    // Reads here see the pre-edge threshold, so a same-edge write only affects later beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FEAT; f++) begin
                for (int j = 0; j < 3; j++) begin
                    thr[f][j] <= IN_W'(thr_init(unsigned'(j), unsigned'(IN_W)));
                end
            end
        end else if (cfg_ok) begin
            thr[cfg_feat][cfg_sel] <= cfg_data;
        end
    end

    quant_cmp3 #(.IN_W(IN_W)) u_cmp (
        .x    (s_data),
        .t0   (thr[idx_q][0]),
        .t1   (thr[idx_q][1]),
        .t2   (thr[idx_q][2]),
        .code (code)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            FILL: begin
                if (s_valid) begin
                    load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        err_d   = !s_last;
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            frame_err <= 1'b0;
            pack_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_err <= err_d;
            if (load) begin
                pack_q[idx_q*Q_W +: Q_W] <= code;
            end
        end
    end

    assign s_ready = (state_q == FILL);
    assign m_valid = (state_q == HOLD);
    assign m_data  = pack_q;

endmodule

// File: tb/tb_input_quantizer_frame.sv
// Self-checking bench: directed frames plus random traffic compared against a frame-level model.
module tb_input_quantizer_frame;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int FW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [2*N-1:0] m_data;
    logic           frame_err;
    logic           cfg_we = 1'b0;
    logic [FW-1:0]  cfg_feat = '0;
    logic [1:0]     cfg_sel = '0;
    logic [W-1:0]   cfg_data = '0;

    int total = 0;
    int bad   = 0;

    input_quantizer_frame #(.NUM_FEAT(N), .IN_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err),
        .cfg_we    (cfg_we),
        .cfg_feat  (cfg_feat),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: thresholds, partial frame, held frame and pending error pulse.
    int             mThr [N][3];
    logic [2*N-1:0] mPart;
    logic [2*N-1:0] mHeld;
    int             mCnt;
    bit             mHold;
    bit             mErr;

    always @(posedge clk or negedge rst_n) begin : model
        int code;
        if (!rst_n) begin
            for (int f = 0; f < N; f++)
                for (int j = 0; j < 3; j++)
                    mThr[f][j] = (j + 1) * (1 << (W - 2));
            mPart = '0;
            mHeld = '0;
            mCnt  = 0;
            mHold = 0;
            mErr  = 0;
        end else begin
            mErr = 0;
            if (!mHold) begin
                if (s_valid) begin
                    code = 0;
                    for (int j = 0; j < 3; j++)
                        if (int'(s_data) >= mThr[mCnt][j]) code++;
                    mPart[2*mCnt +: 2] = 2'(code);
                    if (mCnt == N - 1) begin
                        mHold = 1;
                        mHeld = mPart;
                        mCnt  = 0;
                        mErr  = !s_last;
                    end else if (s_last) begin
                        mCnt = 0;
                        mErr = 1;
                    end else begin
                        mCnt++;
                    end
                end
            end else if (m_ready) begin
                mHold = 0;
            end
            if (cfg_we && cfg_sel != 2'd3 && int'(cfg_feat) < N)
                mThr[cfg_feat][cfg_sel] = int'(cfg_data);
        end
    end

    always @(negedge clk) begin
        checkOutput("s_ready", s_ready, mHold ? 1'b0 : 1'b1);
        checkOutput("m_valid", m_valid, mHold ? 1'b1 : 1'b0);
        checkOutput("frame_err", frame_err, mErr ? 1'b1 : 1'b0);
        if (mHold) checkOutput("m_data", m_data, mHeld);
    end

    // Presents one beat and returns at #1 after the edge on which it was accepted.
    task automatic applyStimulus(input logic [W-1:0] data, input logic last);
        logic readyNow;
        bit   done = 0;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        for (int c = 0; c < 40 && !done; c++) begin
            readyNow = s_ready;
            @(posedge clk);
            #1;
            if (readyNow) done = 1;
        end
        if (!done) checkOutput("accept_timeout", 1'b0, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic cfgWrite(input int feat, input int sel, input int data);
        cfg_we   = 1'b1;
        cfg_feat = FW'(feat);
        cfg_sel  = 2'(sel);
        cfg_data = W'(data);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_m_data", m_data, 8'h00);
        checkOutput("reset_m_valid", m_valid, 1'b0);
        checkOutput("reset_err", frame_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default thresholds 64/128/192.
        applyStimulus(8'd10, 1'b0);
        applyStimulus(8'd64, 1'b0);
        applyStimulus(8'd150, 1'b0);
        applyStimulus(8'd255, 1'b1);
        checkOutput("default_frame", m_data, 8'b11_10_01_00);
        checkOutput("default_valid", m_valid, 1'b1);
        checkOutput("default_err", frame_err, 1'b0);

        // Reprogram feature 0 and ignore a select of 3.
        cfgWrite(0, 0, 5);
        cfgWrite(0, 1, 6);
        cfgWrite(0, 2, 7);
        cfgWrite(1, 3, 0);
        applyStimulus(8'd6, 1'b0);
        applyStimulus(8'd0, 1'b0);
        applyStimulus(8'd0, 1'b0);
        applyStimulus(8'd0, 1'b1);
        checkOutput("reprog_frame", m_data, 8'b00_00_00_10);

        // Early last drops the partial frame.
        applyStimulus(8'd20, 1'b0);
        applyStimulus(8'd30, 1'b1);
        checkOutput("early_err", frame_err, 1'b1);
        checkOutput("early_no_valid", m_valid, 1'b0);
        applyStimulus(8'd200, 1'b0);
        applyStimulus(8'd100, 1'b0);
        applyStimulus(8'd50, 1'b0);
        applyStimulus(8'd0, 1'b1);
        checkOutput("after_early_frame", m_data, 8'b00_00_01_11);
        checkOutput("after_early_err", frame_err, 1'b0);

        // Missing last still emits, with the error coinciding with m_valid.
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd255, 1'b0);
        checkOutput("missing_frame", m_data, 8'hFF);
        checkOutput("missing_err", frame_err, 1'b1);
        checkOutput("missing_valid", m_valid, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure holds the frame while beats are offered.
        m_ready = 1'b0;
        applyStimulus(8'd70, 1'b0);
        applyStimulus(8'd130, 1'b0);
        applyStimulus(8'd190, 1'b0);
        applyStimulus(8'd250, 1'b1);
        for (int c = 0; c < 10; c++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_hold_data", m_data, 8'b11_10_10_11);
            checkOutput("bp_ready_low", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        applyStimulus(8'd7, 1'b0);
        applyStimulus(8'd64, 1'b0);
        applyStimulus(8'd128, 1'b0);
        applyStimulus(8'd192, 1'b1);
        checkOutput("bp_next_frame", m_data, 8'b11_10_01_11);

        // Reset mid-frame restores defaults.
        applyStimulus(8'd1, 1'b0);
        applyStimulus(8'd2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_data", m_data, 8'h00);
        checkOutput("midreset_ready", s_ready, 1'b1);
        rst_n = 1'b1;
        applyStimulus(8'd10, 1'b0);
        cfg_we = 1'b1; cfg_feat = 2'd1; cfg_sel = 2'd0; cfg_data = 8'd200;
        applyStimulus(8'd64, 1'b0);
        cfg_we = 1'b0;
        applyStimulus(8'd150, 1'b0);
        applyStimulus(8'd255, 1'b1);
        checkOutput("post_reset_frame", m_data, 8'b11_10_01_00);
        applyStimulus(8'd0, 1'b0);
        applyStimulus(8'd100, 1'b0);
        applyStimulus(8'd0, 1'b0);
        applyStimulus(8'd0, 1'b1);
        checkOutput("new_thr_frame", m_data, 8'h00);
        checkOutput("new_thr_valid", m_valid, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data   = W'($urandom);
            s_last   = ($urandom_range(0, 5) == 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_feat = FW'($urandom);
            cfg_sel  = 2'($urandom);
            cfg_data = W'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        cfg_we  = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_quantizer_frame.md
# input_quantizer_frame

Streaming front end for the sparse classifier: accepts raw unsigned feature samples one per beat, quantizes each to a 2-bit code against three per-feature thresholds, and packs a full frame of codes into the flat vector that feeds the first neuron layer. A frame is emitted only when complete. Thresholds are runtime-programmable through a small config port.

## Interface
- NUM_FEAT, 16: features per frame; at least 2.
- IN_W, 8: raw feature sample width; at least 3.
- FI_W, $clog2(NUM_FEAT): feature index width; derived, not overridden.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  raw sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  IN_W  unsigned raw sample.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  downstream layer accepts the frame.
- m_data  out  2*NUM_FEAT  packed codes; feature k occupies bits [2k+1:2k].
- frame_err  out  1  one-cycle pulse on a framing error.
- cfg_we  in  1  threshold write strobe.
- cfg_feat  in  FI_W  feature index to write.
- cfg_sel  in  2  threshold select: 0, 1 or 2; a value of 3 is ignored.
- cfg_data  in  IN_W  threshold value to write.

## Operation
- **Thresholds**
  - Register file thr[NUM_FEAT][3].
  - Reset value for every feature: thr[f][j] = (j+1) << (IN_W-2). For IN_W = 8 this gives 64, 128 and 192.
  - Writes with cfg_feat ≥ NUM_FEAT or cfg_sel = 3 are dropped.
- **Quantization**
  - code = (x ≥ thr[i][0]) + (x ≥ thr[i][1]) + (x ≥ thr[i][2]), where i is the current slot index.
  - The result range is 0..3.
  - Thresholds are not required to be monotonic; the sum is computed as stated regardless.
- **FSM**
  - FILL: s_ready = 1 and m_valid = 0. Each accepted beat writes its code into slot idx.
  - Accepted beat, idx = NUM_FEAT-1, s_last = 1: go to HOLD and reset idx to 0.
  - Accepted beat, idx = NUM_FEAT-1, s_last = 0: go to HOLD, reset idx to 0 and pulse frame_err. Every beat completes a frame at this count.
  - Accepted beat, idx < NUM_FEAT-1, s_last = 1 (early last): discard the partial frame, reset idx to 0, stay in FILL and pulse frame_err. No output is produced.
  - HOLD: m_valid = 1, s_ready = 0, and m_data stays stable. When m_valid & m_ready, go to FILL.
- **Outputs**
  - m_data is driven directly from the packed register; there is no combinational path from s_data to m_data.
  - Unwritten slots cannot appear in an emitted frame.

## Timing
- **Reset values:** state = FILL, idx = 0, m_valid = 0, m_data = 0, frame_err = 0, s_ready = 1 once rst_n is high. Thresholds take their reset values.
- **Reset mid-frame:** reset asserted during a frame discards the partial frame and any held frame.
- **Frame timing:** the final sample is accepted at edge n, and m_valid is high after edge n. s_ready returns to 1 in the cycle after the m_ready handshake.
- **Throughput:** best case is NUM_FEAT+1 cycles per frame.
- **Handshakes:** s_ready does not depend on s_valid. m_valid does not depend on m_ready.
- **frame_err:** registered, high for exactly the one cycle after the offending edge.
- **Config write vs data beat:** a config write and a data beat for the same feature on the same edge: the beat uses the old threshold, and the new value applies from the next edge.
- **Config write during HOLD:** the held m_data is unaffected.

## Structure
- **Package quant_pkg:** holds
  - the Q_W = 2 constant;
  - the FILL/HOLD state enum;
  - the reset-threshold function thr_init(j, IN_W).
- **Sub-module quant_cmp3:** a combinational 3-threshold comparator/adder (IN_W in, 2-bit out), instantiated once and shared across slots via idx.
- **Top level:** holds the threshold register file, idx counter, packing register and FSM.

## Test plan
- **Default thresholds:** NUM_FEAT = 4 with default thresholds, samples 10, 64, 150, 255, last on the 4th -> m_data = 8'b11_10_01_00, frame_err stays 0.
- **Threshold reprogram:** write thr[0] = {5, 6, 7}, then send 6, 0, 0, 0 -> slot 0 code = 2.
- **Early last:** s_last on the 2nd sample -> frame_err pulses, no m_valid. The next 4 correct samples produce one frame.
- **Missing last:** 4 samples with no s_last -> the frame is emitted and frame_err pulses on the same edge that m_valid rises.
- **Backpressure:** hold m_ready = 0 for 10 cycles -> m_data stays stable, s_ready = 0, s_valid is ignored. On release, frame n+1 fills correctly.
- **Reset mid-frame:** pulse rst_n low after 2 samples -> all outputs return to their reset values and thresholds return to defaults. The next full frame is correct.
